// File: rtl/g_ram_wr_ctrl_pkg.sv
// Shared types and constants for the g_clk-domain event RAM writer.
// Holds the writer FSM state encoding and the fixed record layout.
package g_ram_wr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_W3   = 3'd4
  } wr_state_t;

  localparam int         REC_WORDS  = 4;
  localparam logic [7:0] REC_MARKER = 8'hA5;

  localparam logic [1:0] W_HDR   = 2'd0;
  localparam logic [1:0] W_CNTLO = 2'd1;
  localparam logic [1:0] W_CNTHI = 2'd2;
  localparam logic [1:0] W_STAT  = 2'd3;

endpackage

// File: rtl/g_ram_wr_ctrl_ring.sv
// Circular record-slot bookkeeping: write/read slot pointers and fill count.
// Ports: clk, rst_n, clr, commit, ack in; wptr, rptr, count, full, empty out.
module g_rec_ring_ptr #(
  parameter int SLOT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 commit,
  input  logic                 ack,
  output logic [SLOT_BITS-1:0] wptr,
  output logic [SLOT_BITS-1:0] rptr,
  output logic [SLOT_BITS:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [SLOT_BITS:0] SLOTS =
    {1'b1, {SLOT_BITS{1'b0}}};

  logic ack_ok;
  logic commit_ok;

  assign full      = (count == SLOTS);
  assign empty     = (count == '0);
  assign ack_ok    = ack & ~empty;
  assign commit_ok = commit & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (commit_ok) wptr <= wptr + 1'b1;
      if (ack_ok)    rptr <= rptr + 1'b1;
      // commit and ack together leave the fill level unchanged
      unique case ({commit_ok, ack_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/g_ram_wr_ctrl.sv
// Serialises captured events into 4-word records in a circular event RAM.
// Ports: g_clk/g_rst_n, capture inputs, RAM write port, reader ack/status.
module g_ram_wr_ctrl
  import g_ram_wr_ctrl_pkg::*;
#(
  parameter int DATASIZE  = 16,
  parameter int COUNTSIZE = 32,
  parameter int ADDRSIZE  = 10
) (
  input  logic                   g_clk,
  input  logic                   g_rst_n,
  input  logic                   g_enable,
  input  logic                   g_clear,
  input  logic                   g_valid,
  input  logic [DATASIZE-1:0]    g_sync2_diff,
  input  logic [2*COUNTSIZE-1:0] g_sync2_diff_count,
  output logic                   ram_we,
  output logic [ADDRSIZE-1:0]    ram_addr,
  output logic [31:0]            ram_wdata,
  input  logic                   g_rd_ack,
  output logic [ADDRSIZE-1:0]    g_rd_base,
  output logic [ADDRSIZE-2:0]    g_rec_count,
  output logic                   g_empty,
  output logic                   g_full,
  output logic [15:0]            g_drop_count,
  output logic                   g_overflow
);

  localparam int SB = ADDRSIZE - 2;
  localparam logic [SB:0] SLOTS_M1 = {1'b0, {SB{1'b1}}};

  wr_state_t              state;
  logic                   hold_valid;
  logic [DATASIZE-1:0]    hold_diff;
  logic [2*COUNTSIZE-1:0] hold_cnt;
  logic [2*COUNTSIZE-1:0] rec_cnt;
  logic [15:0]            seq;

  logic [SB-1:0] wptr;
  logic [SB-1:0] rptr;

  logic          in_idle;
  logic          in_w3;
  logic          ack_ok;
  logic          post_full;
  logic          go_w0;
  logic          full_drop;
  logic          hold_take;
  logic          cap;
  logic          accept;
  logic          drop;
  logic          commit;
  logic [SB-1:0] hdr_slot;
  logic [15:0]   hdr_seq;
  logic [15:0]   hdr_diff;

  g_rec_ring_ptr #(
    .SLOT_BITS(SB)
  ) u_ring (
    .clk   (g_clk),
    .rst_n (g_rst_n),
    .clr   (g_clear),
    .commit(commit),
    .ack   (g_rd_ack),
    .wptr  (wptr),
    .rptr  (rptr),
    .count (g_rec_count),
    .full  (g_full),
    .empty (g_empty)
  );

  assign g_rd_base = {rptr, 2'b00};

  assign in_idle = (state == ST_IDLE);
  assign in_w3   = (state == ST_W3);
  assign ack_ok  = g_rd_ack & ~g_empty;
  assign commit  = in_w3 & ~g_clear;

  // fill level after this cycle's commit (and possible ack)
  assign post_full = ack_ok ? g_full
                            : (g_rec_count == SLOTS_M1);

  assign go_w0 = hold_valid &
                 ((in_idle & ~g_full) |
                  (in_w3 & ~post_full));
  assign full_drop = in_idle & hold_valid & g_full;

  // hold is vacated this cycle, so a new strobe may refill it
  assign hold_take = go_w0 | full_drop;
  assign cap       = g_valid & g_enable;
  assign accept    = cap & (~hold_valid | hold_take);
  assign drop      = full_drop |
                     (cap & hold_valid & ~hold_take);

  // leaving W3 straight into W0 targets the next slot and sequence
  assign hdr_slot = in_w3 ? wptr + 1'b1 : wptr;
  assign hdr_seq  = in_w3 ? seq + 16'd1 : seq;

  always_comb begin
    hdr_diff = '0;
    hdr_diff[DATASIZE-1:0] = hold_diff;
  end

  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state        <= ST_IDLE;
      hold_valid   <= 1'b0;
      hold_diff    <= '0;
      hold_cnt     <= '0;
      rec_cnt      <= '0;
      seq          <= '0;
      g_drop_count <= '0;
      g_overflow   <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else if (g_clear) begin
      state        <= ST_IDLE;
      hold_valid   <= 1'b0;
      seq          <= '0;
      g_drop_count <= '0;
      g_overflow   <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      ram_we <= 1'b0;

      if (accept) begin
        hold_valid <= 1'b1;
        hold_diff  <= g_sync2_diff;
        hold_cnt   <= g_sync2_diff_count;
      end else if (hold_take) begin
        hold_valid <= 1'b0;
      end

      if (drop) begin
        g_overflow <= 1'b1;
        if (g_drop_count != 16'hFFFF)
          g_drop_count <= g_drop_count + 16'd1;
      end

      unique case (state)
        ST_IDLE: begin
          state <= go_w0 ? ST_W0 : ST_IDLE;
        end
        ST_W0: begin
          state     <= ST_W1;
          ram_we    <= 1'b1;
          ram_addr  <= {wptr, W_CNTLO};
          ram_wdata <= rec_cnt[31:0];
        end
        ST_W1: begin
          state     <= ST_W2;
          ram_we    <= 1'b1;
          ram_addr  <= {wptr, W_CNTHI};
          ram_wdata <= rec_cnt[63:32];
        end
        ST_W2: begin
          state     <= ST_W3;
          ram_we    <= 1'b1;
          ram_addr  <= {wptr, W_STAT};
          ram_wdata <= {REC_MARKER, 8'h00, g_drop_count};
        end
        ST_W3: begin
          seq   <= seq + 16'd1;
          state <= go_w0 ? ST_W0 : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (go_w0) begin
        rec_cnt   <= hold_cnt;
        ram_we    <= 1'b1;
        ram_addr  <= {hdr_slot, W_HDR};
        ram_wdata <= {hdr_seq, hdr_diff};
      end
    end
  end

endmodule

// File: tb/tb_g_ram_wr_ctrl.sv
// Directed bench for g_ram_wr_ctrl with a 4-slot ring (ADDRSIZE=4).
// Vector table for single records plus hand-written multi-cycle sequences.
module tb_g_ram_wr_ctrl;

  localparam int DW = 16;
  localparam int CS = 32;
  localparam int AW = 4;

  logic          g_clk = 1'b0;
  logic          g_rst_n = 1'b0;
  logic          g_enable = 1'b0;
  logic          g_clear = 1'b0;
  logic          g_valid = 1'b0;
  logic          g_rd_ack = 1'b0;
  logic [DW-1:0] g_sync2_diff = '0;
  logic [63:0]   g_sync2_diff_count = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [AW-1:0] g_rd_base;
  logic [AW-2:0] g_rec_count;
  logic          g_empty;
  logic          g_full;
  logic [15:0]   g_drop_count;
  logic          g_overflow;

  g_ram_wr_ctrl #(
    .DATASIZE (DW),
    .COUNTSIZE(CS),
    .ADDRSIZE (AW)
  ) dut (
    .g_clk             (g_clk),
    .g_rst_n           (g_rst_n),
    .g_enable          (g_enable),
    .g_clear           (g_clear),
    .g_valid           (g_valid),
    .g_sync2_diff      (g_sync2_diff),
    .g_sync2_diff_count(g_sync2_diff_count),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .g_rd_ack          (g_rd_ack),
    .g_rd_base         (g_rd_base),
    .g_rec_count       (g_rec_count),
    .g_empty           (g_empty),
    .g_full            (g_full),
    .g_drop_count      (g_drop_count),
    .g_overflow        (g_overflow)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] wq[$];

  always @(negedge g_clk)
    if (ram_we) wq.push_back({ram_addr, ram_wdata});

  typedef struct {
    logic [15:0]   diff;
    logic [63:0]   cnt;
    logic [AW-1:0] base;
    logic [31:0]   w0, w1, w2, w3;
    logic [AW-2:0] n_after;
    logic [AW-1:0] rdb_after;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge g_clk);
  endtask

  task automatic send(input logic [15:0] d,
                      input logic [63:0] c);
    @(negedge g_clk);
    g_valid = 1'b1;
    g_sync2_diff = d;
    g_sync2_diff_count = c;
    @(negedge g_clk);
    g_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge g_clk);
    g_rd_ack = 1'b1;
    @(negedge g_clk);
    g_rd_ack = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge g_clk);
    g_clear = 1'b1;
    @(negedge g_clk);
    g_clear = 1'b0;
  endtask

  task automatic get_wr(output logic [AW-1:0] a,
                        output logic [31:0] d,
                        output bit ok);
    int t = 0;
    while (wq.size() == 0 && t < 60) begin
      @(negedge g_clk);
      t++;
    end
    if (wq.size() == 0) begin
      ok = 1'b0;
      a = '0;
      d = '0;
    end else begin
      {a, d} = wq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic wait_addr(input logic [AW-1:0] a,
                           output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < 60 && !ok) begin
      @(negedge g_clk);
      t++;
      if (ram_we && ram_addr == a) ok = 1'b1;
    end
  endtask

  task automatic expect_rec(input string nm,
                            input logic [AW-1:0] base,
                            input logic [31:0] w0,
                            input logic [31:0] w1,
                            input logic [31:0] w2,
                            input logic [31:0] w3);
    logic [31:0]   w[4];
    logic [AW-1:0] a;
    logic [AW-1:0] ea;
    logic [31:0]   d;
    bit            ok;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    w[3] = w3;
    for (int k = 0; k < 4; k++) begin
      get_wr(a, d, ok);
      ea = base + k[AW-1:0];
      chk($sformatf("%s_seen%0d", nm, k), 64'(ok), 64'd1);
      chk($sformatf("%s_addr%0d", nm, k), 64'(a), 64'(ea));
      chk($sformatf("%s_data%0d", nm, k), 64'(d), 64'(w[k]));
    end
  endtask

  initial begin
    bit ok;

    tbl[0] = '{16'h0123, 64'h0000_0001_0000_0002, 4'd0,
               32'h0000_0123, 32'h0000_0002,
               32'h0000_0001, 32'hA500_0000, 3'd1, 4'd0};
    tbl[1] = '{16'hFFFF, 64'hDEAD_BEEF_CAFE_F00D, 4'd4,
               32'h0001_FFFF, 32'hCAFE_F00D,
               32'hDEAD_BEEF, 32'hA500_0000, 3'd1, 4'd4};
    tbl[2] = '{16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8,
               32'h0002_0000, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hA500_0000, 3'd1, 4'd8};

    // reset state
    tick(2);
    chk("rst_we", 64'(ram_we), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_wdata", 64'(ram_wdata), 64'd0);
    chk("rst_count", 64'(g_rec_count), 64'd0);
    chk("rst_empty", 64'(g_empty), 64'd1);
    chk("rst_full", 64'(g_full), 64'd0);
    chk("rst_drop", 64'(g_drop_count), 64'd0);
    chk("rst_ovf", 64'(g_overflow), 64'd0);
    chk("rst_rdbase", 64'(g_rd_base), 64'd0);
    @(negedge g_clk);
    g_rst_n = 1'b1;

    // capture disabled: strobes ignored, nothing dropped
    send(16'h1111, 64'd1);
    send(16'h2222, 64'd2);
    send(16'h3333, 64'd3);
    tick(10);
    chk("dis_nowr", 64'(wq.size()), 64'd0);
    chk("dis_drop", 64'(g_drop_count), 64'd0);
    chk("dis_count", 64'(g_rec_count), 64'd0);
    ack_pulse();
    tick(1);
    chk("ackempty_count", 64'(g_rec_count), 64'd0);
    chk("ackempty_rdbase", 64'(g_rd_base), 64'd0);
    g_enable = 1'b1;

    // table: single records, each consumed afterwards
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].diff, tbl[i].cnt);
      expect_rec($sformatf("vec%0d", i), tbl[i].base,
                 tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3);
      tick(2);
      chk($sformatf("vec%0d_count", i),
          64'(g_rec_count), 64'(tbl[i].n_after));
      chk($sformatf("vec%0d_rdbase", i),
          64'(g_rd_base), 64'(tbl[i].rdb_after));
      ack_pulse();
      tick(1);
      chk($sformatf("vec%0d_empty", i), 64'(g_empty), 64'd1);
    end

    // back-to-back strobes: two recorded, third dropped
    clear_pulse();
    @(negedge g_clk);
    g_valid = 1'b1;
    g_sync2_diff = 16'h0011;
    g_sync2_diff_count = 64'd1;
    @(negedge g_clk);
    g_sync2_diff = 16'h0022;
    g_sync2_diff_count = 64'd2;
    @(negedge g_clk);
    g_sync2_diff = 16'h0033;
    g_sync2_diff_count = 64'd3;
    @(negedge g_clk);
    g_valid = 1'b0;
    expect_rec("b2b_a", 4'd0, 32'h0000_0011, 32'd1,
               32'd0, 32'hA500_0001);
    expect_rec("b2b_b", 4'd4, 32'h0001_0022, 32'd2,
               32'd0, 32'hA500_0001);
    tick(6);
    chk("b2b_nowr3", 64'(wq.size()), 64'd0);
    chk("b2b_drop", 64'(g_drop_count), 64'd1);
    chk("b2b_ovf", 64'(g_overflow), 64'd1);
    chk("b2b_count", 64'(g_rec_count), 64'd2);

    // commit coinciding with ack at count=2
    send(16'h0044, 64'h0000_0009_0000_0008);
    wait_addr(4'd11, ok);
    chk("cc_w3seen", 64'(ok), 64'd1);
    g_rd_ack = 1'b1;
    @(negedge g_clk);
    g_rd_ack = 1'b0;
    expect_rec("cc", 4'd8, 32'h0002_0044, 32'd8,
               32'd9, 32'hA500_0001);
    tick(1);
    chk("cc_count", 64'(g_rec_count), 64'd2);
    chk("cc_rdbase", 64'(g_rd_base), 64'd4);

    // fill the 4-slot ring, drop the fifth, then wrap
    clear_pulse();
    for (int i = 0; i < 4; i++) begin
      send(16'h0100 + 16'(i), 64'(i));
      expect_rec($sformatf("fill%0d", i), 4'(4 * i),
                 {16'(i), 16'h0100 + 16'(i)},
                 32'(i), 32'd0, 32'hA500_0000);
      tick(2);
    end
    send(16'h0105, 64'd5);
    tick(10);
    chk("fill_nowr5", 64'(wq.size()), 64'd0);
    chk("fill_full", 64'(g_full), 64'd1);
    chk("fill_count", 64'(g_rec_count), 64'd4);
    chk("fill_drop", 64'(g_drop_count), 64'd1);
    chk("fill_ovf", 64'(g_overflow), 64'd1);
    ack_pulse();
    tick(1);
    chk("fill_ack_count", 64'(g_rec_count), 64'd3);
    chk("fill_ack_rdbase", 64'(g_rd_base), 64'd4);
    chk("fill_ack_full", 64'(g_full), 64'd0);
    send(16'h0066, 64'd6);
    expect_rec("wrap", 4'd0, 32'h0004_0066, 32'd6,
               32'd0, 32'hA500_0001);
    tick(2);
    chk("wrap_count", 64'(g_rec_count), 64'd4);

    // clear in W1 aborts record; strobe in clear cycle discarded
    ack_pulse();
    send(16'h0077, 64'd1);
    wait_addr(4'd5, ok);
    chk("clr_w1seen", 64'(ok), 64'd1);
    g_clear = 1'b1;
    g_valid = 1'b1;
    g_sync2_diff = 16'h0088;
    @(negedge g_clk);
    g_clear = 1'b0;
    g_valid = 1'b0;
    chk("clr_we", 64'(ram_we), 64'd0);
    chk("clr_count", 64'(g_rec_count), 64'd0);
    chk("clr_rdbase", 64'(g_rd_base), 64'd0);
    chk("clr_drop", 64'(g_drop_count), 64'd0);
    chk("clr_ovf", 64'(g_overflow), 64'd0);
    chk("clr_partial", 64'(wq.size()), 64'd2);
    wq.delete();
    tick(6);
    chk("clr_nowr", 64'(wq.size()), 64'd0);
    send(16'h0055, 64'd7);
    expect_rec("post_clr", 4'd0, 32'h0000_0055, 32'd7,
               32'd0, 32'hA500_0000);
    tick(2);
    chk("post_clr_count", 64'(g_rec_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/g_ram_wr_ctrl.md
Name: g_ram_wr_ctrl

Overview:
Write-side controller for the event RAM in the g_clk domain. It consumes synchronised event pulses with their difference and count values and serialises each event into a fixed 4-word record. It manages the RAM as a circular record buffer against a downstream reader, and it handles full-buffer drops and statistics. The block sits between the clock-domain-crossing stage and the dual-port event RAM; the readout logic drains the RAM via the other port.

Parameters:
DATASIZE, 16, width of event difference value; must be ≤16
COUNTSIZE, 32, half-width of event count; event count is 2*COUNTSIZE = 64 bits, fixed at COUNTSIZE=32
ADDRSIZE, 10, RAM word address width; record slots = 2^(ADDRSIZE-2)

Ports:
g_clk  in  1  sole clock
g_rst_n  in  1  asynchronous, active-low reset
g_enable  in  1  capture enable; level
g_clear  in  1  synchronous clear of buffer and statistics; single-cycle pulse
g_valid  in  1  one-cycle event strobe from the CDC stage
g_sync2_diff  in  DATASIZE  event difference, valid with g_valid
g_sync2_diff_count  in  2*COUNTSIZE  event count, valid with g_valid
ram_we  out  1  RAM write enable
ram_addr  out  ADDRSIZE  RAM word address = {slot, word index}
ram_wdata  out  32  RAM write data
g_rd_ack  in  1  pulse: reader has consumed the oldest record
g_rd_base  out  ADDRSIZE  word address of the oldest unread record = {rptr, 2'b00}
g_rec_count  out  ADDRSIZE-1  records held, 0..2^(ADDRSIZE-2)
g_empty  out  1  g_rec_count==0
g_full  out  1  g_rec_count==2^(ADDRSIZE-2)
g_drop_count  out  16  saturating count of dropped events
g_overflow  out  1  sticky flag: at least one drop since reset or clear

Behaviour:
- Reset: FSM=IDLE; wptr, rptr, g_rec_count, seq, g_drop_count, g_overflow, hold_valid, ram_we, ram_addr, ram_wdata all 0; g_empty=1, g_full=0.
- Capture:
  - g_valid & g_enable with hold_valid=0: latch diff, count into the hold register; set hold_valid.
  - g_valid while hold_valid=1: drop the event.
  - g_valid with g_enable=0: ignore, no drop counted.
- FSM states: IDLE, W0, W1, W2, W3.
- IDLE, hold_valid & !g_full: move hold to the record register, clear hold_valid, go to W0.
- IDLE, hold_valid & g_full: drop the held event, clear hold_valid, stay in IDLE.
- Wk (k=0..3): ram_we=1, ram_addr={wptr, k}. ram_we is 0 in IDLE.
  - W0 data: {seq[15:0], zero-extended diff}.
  - W1 data: count[31:0].
  - W2 data: count[63:32].
  - W3 data: {8'hA5, 8'h00, g_drop_count snapshot}.
- W3 exit: wptr+1 (wraps mod slots), seq+1 (wraps at 16 bits), record committed.
- W3 next state: W0 if hold_valid & the post-commit count is not full; else IDLE, where the full-drop rule applies.
- Latency: g_valid in cycle N, record in W0 at cycle N+2 at the earliest. Sustained throughput is 1 record per 4 cycles.
- g_rd_ack with !g_empty: rptr+1, count-1. g_rd_ack when empty: ignored.
- Commit and g_rd_ack in the same cycle: count unchanged, both pointers advance. A full buffer plus an ack in the same cycle as the IDLE decision still drops, because the decision uses registered g_full.
- Drop (any cause): g_drop_count+1, saturating at 16'hFFFF; g_overflow set.
- g_clear: highest priority. Zeroes pointers, count, seq, drop count, overflow, and hold. Forces IDLE and ram_we=0 next cycle, aborting any partial record, which is never committed. An event strobe in the g_clear cycle is discarded.
- g_enable deasserted mid-record: the current record and a pending hold complete normally.
- Asynchronous reset mid-record: outputs return to reset values immediately; RAM content is don't-care.

Decomposition:
- Shared package:
  - FSM state enum
  - REC_WORDS=4
  - REC_MARKER=8'hA5
  - word index constants W_HDR=0, W_CNTLO=1, W_CNTHI=2, W_STAT=3
- One natural sub-module, g_rec_ring_ptr: wptr/rptr/count/full/empty with commit and ack inputs and simultaneous-event handling.

Test Plan:
1. Single event, diff=16'h0123, count=64'h0000_0001_0000_0002 -> writes at addr 0..3 = 32'h0000_0123, 32'h0000_0002, 32'h0000_0001, 32'hA500_0000. Then count=1, rd_base=0.
2. Three g_valid pulses one cycle apart -> events 1 and 2 recorded with seq 0 and 1, event 3 dropped. g_drop_count=1, overflow=1. Record 2 W3 word = 32'hA500_0001.
3. ADDRSIZE=4 (4 slots), 5 spaced events and no acks -> 4 records, full=1, 5th dropped. Then 1 ack -> count=3, rd_base=4. Next event is written at addr 0..3 (wrap).
4. Commit in the same cycle as g_rd_ack with count=2 -> count stays 2, rd_base advances by 4.
5. g_clear asserted during W1 -> ram_we=0 next cycle. Pointers, count, drop count and seq are 0. The next event is written at addr 0 with seq 0.
6. g_enable=0 with 3 events -> no writes, drop_count 0. g_rd_ack while empty -> count stays 0, rd_base stays 0.
